// File: rtl/enc_pkg.sv
// enc_pkg: shared Gray encodings, direction constants and quadrature step decode
package enc_pkg;
  localparam logic [1:0] ST_00 = 2'b00;
  localparam logic [1:0] ST_01 = 2'b01;
  localparam logic [1:0] ST_11 = 2'b11;
  localparam logic [1:0] ST_10 = 2'b10;
  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;
  typedef enum logic [1:0] {STEP_NONE, STEP_CW, STEP_CCW, STEP_ILL} step_e;
  // Clockwise successor of {a,b} is {b,~a}; both bits flipping at once is illegal.
  function automatic step_e step_decode(input logic [1:0] prev, input logic [1:0] cur);
    return (prev == cur) ? STEP_NONE :
           ((prev ^ cur) == 2'b11) ? STEP_ILL :
           (cur == {prev[0], ~prev[1]}) ? STEP_CW : STEP_CCW;
  endfunction
endpackage

// File: rtl/enc_debounce.sv
// enc_debounce: 2-FF synchroniser followed by a stability-counting debouncer
module enc_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic deb_o
);
  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  logic s1_q, s2_q, deb_q, deb_d, hit;
  logic [CW-1:0] cnt_q, cnt_d;
  // Count consecutive samples that differ from the output; any agreement restarts the count.
  always_comb begin
    hit = (s2_q != deb_q) && (cnt_q == CW'(DEB_CYCLES - 1));
    cnt_d = (s2_q == deb_q || hit) ? '0 : cnt_q + 1'b1;
    deb_d = hit ? s2_q : deb_q;
  end
  // Synchroniser, stability counter and debounced level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
      cnt_q <= cnt_d;
      deb_q <= deb_d;
    end
  end
  assign deb_o = deb_q;
endmodule

// File: rtl/quad_encoder_array.sv
// quad_encoder_array: multi-channel debounced quadrature decoder with counters and buttons
module quad_encoder_array #(
  parameter int CHANNELS   = 2,
  parameter int CNT_W      = 8,
  parameter int MAX        = 120,
  parameter int DEB_CYCLES = 16,
  parameter int WRAP       = 1,
  parameter int X4         = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       a_in,
  input  logic [CHANNELS-1:0]       b_in,
  input  logic [CHANNELS-1:0]       btn_in,
  output logic [CHANNELS*CNT_W-1:0] count,
  output logic [CHANNELS-1:0]       dir,
  output logic [CHANNELS-1:0]       step,
  output logic [CHANNELS-1:0]       btn_press,
  output logic [CHANNELS-1:0]       err
);
  import enc_pkg::*;
  logic [3*CHANNELS-1:0] raw, deb;
  assign raw = {btn_in, b_in, a_in};
  for (genvar i = 0; i < 3 * CHANNELS; i++) begin : g_deb
    enc_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk(clk), .rst(rst), .raw_i(raw[i]), .deb_o(deb[i])
    );
  end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [1:0] st_q, cur;
    step_e sd;
    logic [CNT_W-1:0] cnt_q, cnt_d, inc, dec;
    logic btn_q, press_d, press_q, step_d, step_q, dir_d, dir_q, err_d, err_q;
    // Decode the debounced Gray transition, apply bounds, and let a button press clear count and err.
    always_comb begin
      cur = {deb[c], deb[CHANNELS+c]};
      sd = step_decode(st_q, cur);
      press_d = deb[2*CHANNELS+c] & ~btn_q;
      step_d = (sd == STEP_CW || sd == STEP_CCW) && (X4 != 0 || cur == ST_00);
      inc = (cnt_q == CNT_W'(MAX)) ? ((WRAP != 0) ? '0 : cnt_q) : cnt_q + 1'b1;
      dec = (cnt_q == '0) ? ((WRAP != 0) ? CNT_W'(MAX) : cnt_q) : cnt_q - 1'b1;
      cnt_d = press_d ? '0 : !step_d ? cnt_q : (sd == STEP_CW) ? inc : dec;
      dir_d = step_d ? ((sd == STEP_CW) ? DIR_CW : DIR_CCW) : dir_q;
      err_d = !press_d && (err_q || sd == STEP_ILL);
    end
    // Per-channel registered state and outputs.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_q <= ST_00;
        btn_q <= 1'b0;
        cnt_q <= '0;
        dir_q <= 1'b0;
        step_q <= 1'b0;
        press_q <= 1'b0;
        err_q <= 1'b0;
      end else begin
        st_q <= cur;
        btn_q <= deb[2*CHANNELS+c];
        cnt_q <= cnt_d;
        dir_q <= dir_d;
        step_q <= step_d;
        press_q <= press_d;
        err_q <= err_d;
      end
    end
    assign count[c*CNT_W +: CNT_W] = cnt_q;
    assign dir[c] = dir_q;
    assign step[c] = step_q;
    assign btn_press[c] = press_q;
    assign err[c] = err_q;
  end
endmodule

// File: tb/tb_quad_encoder_array.sv
// tb_quad_encoder_array: scoreboard bench over four WRAP/X4 variants sharing one stimulus
module tb_quad_encoder_array;
  localparam int ND = 4;
  localparam int LAT = 7;
  typedef struct {
    int cyc;
    int cnt;
    int dir;
    int err;
    int stp;
    int prs;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] a_in = '0, b_in = '0, btn_in = '0;
  logic [15:0] cnt_w [ND];
  logic [1:0] dir_w [ND], step_w [ND], prs_w [ND], err_w [ND];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t sb [2*ND][$];
  int idx [2];
  int mcnt [ND][2];
  int mdir [ND][2];
  int merr [ND][2];
  int gr [4] = '{0, 1, 3, 2};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    quad_encoder_array #(
      .CHANNELS(2), .CNT_W(8), .MAX(120), .DEB_CYCLES(4),
      .WRAP((g % 2 == 0) ? 1 : 0), .X4(g / 2)
    ) u_dut (
      .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .btn_in(btn_in),
      .count(cnt_w[g]), .dir(dir_w[g]), .step(step_w[g]),
      .btn_press(prs_w[g]), .err(err_w[g])
    );
  end

  function automatic int gcnt(input int d, input int c);
    return int'(cnt_w[d][c*8 +: 8]);
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      idx[c] = 0;
      for (int d = 0; d < ND; d++) begin
        mcnt[d][c] = 0;
        mdir[d][c] = 0;
        merr[d][c] = 0;
      end
    end
  endtask

  task automatic check_all(input string nm);
    for (int d = 0; d < ND; d++)
      for (int c = 0; c < 2; c++) begin
        chk($sformatf("%s cnt d%0d ch%0d", nm, d, c), gcnt(d, c), mcnt[d][c]);
        chk($sformatf("%s dir d%0d ch%0d", nm, d, c), int'(dir_w[d][c]), mdir[d][c]);
        chk($sformatf("%s err d%0d ch%0d", nm, d, c), int'(err_w[d][c]), merr[d][c]);
      end
  endtask

  // kinds: 0 none, 1 cw, 2 ccw, 3 illegal, 4 press, 5 cw+press
  task automatic apply(input int c, input int k);
    int mv;
    bit cw, rot, prs, st, w, x4;
    exp_t e;
    if (k == 0) return;
    cw = (k == 1 || k == 5);
    rot = cw || k == 2;
    prs = (k == 4 || k == 5);
    mv = cw ? 1 : (k == 2) ? 3 : (k == 3) ? 2 : 0;
    idx[c] = (idx[c] + mv) % 4;
    a_in[c] = gr[idx[c]][1];
    b_in[c] = gr[idx[c]][0];
    if (prs) btn_in[c] = 1'b1;
    for (int d = 0; d < ND; d++) begin
      w = (d % 2 == 0);
      x4 = (d / 2 != 0);
      st = rot && (x4 || idx[c] == 0);
      if (st) begin
        mdir[d][c] = cw ? 1 : 0;
        if (cw) mcnt[d][c] = (mcnt[d][c] == 120) ? (w ? 0 : 120) : mcnt[d][c] + 1;
        else mcnt[d][c] = (mcnt[d][c] == 0) ? (w ? 120 : 0) : mcnt[d][c] - 1;
      end
      if (k == 3) merr[d][c] = 1;
      if (prs) begin
        mcnt[d][c] = 0;
        merr[d][c] = 0;
      end
      if (st || prs) begin
        e.cyc = cyc + LAT;
        e.cnt = mcnt[d][c];
        e.dir = mdir[d][c];
        e.err = merr[d][c];
        e.stp = st ? 1 : 0;
        e.prs = prs ? 1 : 0;
        sb[d*2+c].push_back(e);
      end
    end
  endtask

  task automatic ev(input int k0, input int k1, input int h);
    apply(0, k0);
    apply(1, k1);
    wait_cyc(h);
    if (btn_in != 2'b00) begin
      btn_in = 2'b00;
      wait_cyc(h);
    end
  endtask

  function automatic int rk();
    int r;
    r = $urandom_range(0, 9);
    return (r < 3) ? 1 : (r < 6) ? 2 : (r == 6) ? 3 : (r == 7) ? 4 : (r == 8) ? 5 : 0;
  endfunction

  // Monitor: every step/press pulse pops and compares the oldest expectation for that DUT/channel.
  always @(negedge clk) begin
    exp_t e;
    int k;
    for (int d = 0; d < ND; d++)
      for (int c = 0; c < 2; c++) begin
        k = d * 2 + c;
        if (sb[k].size() != 0 && sb[k][0].cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL missed d%0d ch%0d: no pulse by cyc %0d, want one at %0d", d, c, cyc, sb[k][0].cyc);
          void'(sb[k].pop_front());
        end
        if (step_w[d][c] || prs_w[d][c]) begin
          checks++;
          if (sb[k].size() == 0) begin
            errors++;
            $display("FAIL spurious d%0d ch%0d: step=%0d press=%0d at cyc %0d, want none",
                     d, c, step_w[d][c], prs_w[d][c], cyc);
          end else begin
            e = sb[k].pop_front();
            if (e.cyc != cyc || e.cnt != gcnt(d, c) || e.dir != int'(dir_w[d][c]) ||
                e.err != int'(err_w[d][c]) || e.stp != int'(step_w[d][c]) || e.prs != int'(prs_w[d][c])) begin
              errors++;
              $display("FAIL sb d%0d ch%0d: got cyc=%0d cnt=%0d dir=%0d err=%0d step=%0d press=%0d want cyc=%0d cnt=%0d dir=%0d err=%0d step=%0d press=%0d",
                       d, c, cyc, gcnt(d, c), dir_w[d][c], err_w[d][c], step_w[d][c], prs_w[d][c],
                       e.cyc, e.cnt, e.dir, e.err, e.stp, e.prs);
            end
          end
        end
      end
  end

  initial begin
    model_reset();
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(20);
    check_all("reset_idle");
    // four clean clockwise quadrature steps on ch0, one detent
    repeat (4) ev(1, 0, 10);
    check_all("detent");
    chk("detent cnt0 x1", gcnt(0, 0), 1);
    chk("detent cnt0 x4", gcnt(2, 0), 4);
    chk("detent dir0", int'(dir_w[0][0]), 1);
    chk("detent cnt1", gcnt(0, 1), 0);
    ev(4, 0, 8);
    // climb to MAX, then cross the upper and lower bounds
    repeat (120) repeat (4) ev(1, 0, 8);
    chk("at max wrap", gcnt(0, 0), 120);
    chk("at max sat", gcnt(1, 0), 120);
    repeat (4) ev(1, 0, 8);
    chk("cw past max wrap", gcnt(0, 0), 0);
    chk("cw past max sat", gcnt(1, 0), 120);
    repeat (4) ev(2, 0, 8);
    chk("ccw wrap", gcnt(0, 0), 120);
    chk("ccw sat", gcnt(1, 0), 119);
    check_all("bounds");
    // short glitches on a_in[0] must be filtered out
    repeat (3) begin
      a_in[0] = ~a_in[0];
      wait_cyc(3);
      a_in[0] = ~a_in[0];
      wait_cyc(6);
    end
    wait_cyc(10);
    check_all("glitch");
    chk("glitch err0", int'(err_w[0][0]), 0);
    // illegal double toggle, then button clear
    ev(3, 0, 8);
    check_all("illegal");
    chk("illegal err0", int'(err_w[0][0]), 1);
    chk("illegal cnt0", gcnt(0, 0), 120);
    ev(4, 0, 8);
    chk("clear err0", int'(err_w[0][0]), 0);
    chk("clear cnt0", gcnt(0, 0), 0);
    // detent and press coincide on ch1
    repeat (3) ev(0, 1, 8);
    ev(0, 5, 8);
    chk("coincide cnt1", gcnt(0, 1), 0);
    check_all("coincide");
    // randomized independent activity on both channels
    repeat (150) ev(rk(), rk(), 8);
    check_all("random");
    // reset in the middle of a debounce window
    a_in[0] = ~a_in[0];
    b_in[1] = ~b_in[1];
    wait_cyc(3);
    rst = 1'b1;
    a_in = '0;
    b_in = '0;
    btn_in = '0;
    model_reset();
    #1;
    chk("async rst cnt0", gcnt(2, 0), 0);
    chk("async rst cnt1", gcnt(2, 1), 0);
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(20);
    check_all("post reset");
    for (int k = 0; k < 2 * ND; k++) chk($sformatf("pending q%0d", k), sb[k].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
